// File: rtl/bf16_mul_norm_round.sv
// bfloat16 multiply back end: normalize the mantissa product, round to nearest-even, pack the result.
// Optional MUL_STATUS_STICKY_EN adds a sticky {Overflow,Underflow,Inexact} status register with a clear input.
module bf16_mul_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 7,
  parameter int BIAS   = 127
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic                        Sign_In,
  input  logic [EXP_W+1:0]            Exp_In,
  input  logic [2*(FRAC_W+1)-1:0]     Product,
  input  logic                        Is_NaN,
  input  logic                        Is_Inf,
  input  logic                        Is_Zero,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [EXP_W+FRAC_W:0]       Result,
  output logic                        Overflow,
  output logic                        Underflow,
  output logic                        Inexact
`ifdef MUL_STATUS_STICKY_EN
  ,
  input  logic                        Status_Clr,
  output logic [2:0]                  Status
`endif
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * (FRAC_W + 1);
  localparam int RW  = 1 + EXP_W + FRAC_W;

  // BIAS is already folded into Exp_In upstream; it only fixes the meaning of the exponent field here.
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;
  localparam logic [RW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // Stage 1 state
  logic                    s1_valid;
  logic                    s1_sign;
  logic signed [EW2-1:0]   s1_exp;
  logic [FRAC_W-1:0]       s1_frac;
  logic                    s1_g;
  logic                    s1_s;
  logic                    s1_nan;
  logic                    s1_inf;
  logic                    s1_zero;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !Out_Valid || Out_Ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign In_Ready = s1_adv;

  // Normalize: a product in [2,4) shifts right by one and bumps the exponent.
  logic                  norm_msb;
  logic [FRAC_W-1:0]     norm_frac;
  logic                  norm_g;
  logic                  norm_s;
  logic signed [EW2-1:0] norm_exp;

  assign norm_msb = Product[PW-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    norm_frac = Product[PW-3 -: FRAC_W];
    norm_g    = Product[FRAC_W-1];
    norm_s    = |Product[FRAC_W-2:0];
    norm_exp  = $signed(Exp_In);
    if (norm_msb) begin
      norm_frac = Product[PW-2 -: FRAC_W];
      norm_g    = Product[FRAC_W];
      norm_s    = |Product[FRAC_W-1:0];
      norm_exp  = $signed(Exp_In) + EW2'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= In_Valid;
      if (In_Valid) begin
        s1_sign <= Sign_In;
        s1_exp  <= norm_exp;
        s1_frac <= norm_frac;
        s1_g    <= norm_g;
        s1_s    <= norm_s;
        s1_nan  <= Is_NaN;
        s1_inf  <= Is_Inf;
        s1_zero <= Is_Zero;
      end
    end
  end

  // Stage 2: round to nearest-even, then judge range on the post-round exponent.
  logic                  rnd_inc;
  logic [FRAC_W:0]       rnd_sum;
  logic [FRAC_W-1:0]     rnd_frac;
  logic signed [EW2-1:0] rnd_exp;
  logic [RW-1:0]         res_n;
  logic                  ovf_n;
  logic                  unf_n;
  logic                  inx_n;

  assign rnd_inc  = s1_g && (s1_s || s1_frac[0]);
  assign rnd_sum  = {1'b0, s1_frac} + {{FRAC_W{1'b0}}, rnd_inc};
  assign rnd_frac = rnd_sum[FRAC_W-1:0];
  assign rnd_exp  = s1_exp + $signed({{(EW2-1){1'b0}}, rnd_sum[FRAC_W]});

  always_comb begin
    res_n = {s1_sign, rnd_exp[EXP_W-1:0], rnd_frac};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inx_n = s1_g || s1_s;
    if (s1_nan) begin
      res_n = QNAN;
      inx_n = 1'b0;
    end else if (s1_inf) begin
      res_n = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      inx_n = 1'b0;
    end else if (s1_zero) begin
      res_n = {s1_sign, {(RW-1){1'b0}}};
      inx_n = 1'b0;
    end else if (rnd_exp >= EXP_MAX) begin
      res_n = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_n = 1'b1;
      inx_n = 1'b1;
    end else if (rnd_exp <= EXP_ZERO) begin
      res_n = {s1_sign, {(RW-1){1'b0}}};
      unf_n = 1'b1;
      inx_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Out_Valid <= 1'b0;
      Result    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Inexact   <= 1'b0;
    end else if (s2_adv) begin
      Out_Valid <= s1_valid;
      if (s1_valid) begin
        Result    <= res_n;
        Overflow  <= ovf_n;
        Underflow <= unf_n;
        Inexact   <= inx_n;
      end
    end
  end

`ifdef MUL_STATUS_STICKY_EN
  // Clear and a same-cycle transfer combine so the new flags survive the clear.
  logic       out_xfer;
  logic [2:0] xfer_flags;

  assign out_xfer   = Out_Valid && Out_Ready;
  assign xfer_flags = out_xfer ? {Overflow, Underflow, Inexact} : 3'b000;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Status <= 3'b000;
    end else begin
      Status <= (Status_Clr ? 3'b000 : Status) | xfer_flags;
    end
  end
`endif

endmodule

// File: tb/tb_bf16_mul_norm_round.sv
// Directed self-checking bench for bf16_mul_norm_round: rounding, range, specials, backpressure, reset.
// Sticky status checks run only when MUL_STATUS_STICKY_EN is defined.
module tb_bf16_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [9:0]  exp_in = '0;
  logic [15:0] product = '0;
  logic        is_nan = 1'b0;
  logic        is_inf = 1'b0;
  logic        is_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;
`ifdef MUL_STATUS_STICKY_EN
  logic        status_clr = 1'b0;
  logic [2:0]  status;
`endif

  int checks = 0;
  int errors = 0;

  bf16_mul_norm_round dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .Sign_In   (sign_in),
    .Exp_In    (exp_in),
    .Product   (product),
    .Is_NaN    (is_nan),
    .Is_Inf    (is_inf),
    .Is_Zero   (is_zero),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Result    (result),
    .Overflow  (overflow),
    .Underflow (underflow),
    .Inexact   (inexact)
`ifdef MUL_STATUS_STICKY_EN
    ,
    .Status_Clr(status_clr),
    .Status    (status)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [15:0] p,
                       input logic n, input logic i, input logic z);
    sign_in  = s;
    exp_in   = e;
    product  = p;
    is_nan   = n;
    is_inf   = i;
    is_zero  = z;
    in_valid = 1'b1;
  endtask

  // Present one input and hold it until accepted, bounded by a cycle budget.
  task automatic send(input string tag, input logic s, input logic [9:0] e, input logic [15:0] p,
                      input logic n, input logic i, input logic z);
    int waited = 0;
    drive(s, e, p, n, i, z);
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_accept"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // One transaction through an idle pipe: output must appear exactly two edges after presentation.
  task automatic vec(input string tag, input logic s, input logic [9:0] e, input logic [15:0] p,
                     input logic n, input logic i, input logic z,
                     input logic [15:0] exp_res, input logic [2:0] exp_flags);
    out_ready = 1'b1;
    send(tag, s, e, p, n, i, z);
    check({tag, "_pre"}, out_valid, 1'b0);
    step();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, {overflow, underflow, inexact}, exp_flags);
  endtask

  initial begin
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_flags", {overflow, underflow, inexact}, 3'b000);
    step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", in_ready, 1'b1);

    // Flags are {Overflow, Underflow, Inexact}.
    vec("exact",       1'b0, 10'd127, 16'h9000, 1'b0, 1'b0, 1'b0, 16'h4010, 3'b000);
    vec("exact_neg",   1'b1, 10'd127, 16'h9000, 1'b0, 1'b0, 1'b0, 16'hC010, 3'b000);
    vec("tie_up",      1'b0, 10'd127, 16'h40C0, 1'b0, 1'b0, 1'b0, 16'h3F82, 3'b001);
    vec("tie_even",    1'b0, 10'd127, 16'h4040, 1'b0, 1'b0, 1'b0, 16'h3F80, 3'b001);
    vec("rnd_carry",   1'b0, 10'd127, 16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h4000, 3'b001);
    vec("ovf_direct",  1'b0, 10'd254, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h7F80, 3'b101);
    vec("ovf_by_rnd",  1'b1, 10'd253, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFF80, 3'b101);
    vec("max_finite",  1'b0, 10'd254, 16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h7F80, 3'b101);
    vec("below_max",   1'b0, 10'd254, 16'h7F00, 1'b0, 1'b0, 1'b0, 16'h7F7E, 3'b000);
    vec("unf",         1'b1, 10'd0,   16'h4000, 1'b0, 1'b0, 1'b0, 16'h8000, 3'b011);
    vec("unf_neg_exp", 1'b0, 10'h3F6, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b011);
    vec("min_normal",  1'b0, 10'd1,   16'h4000, 1'b0, 1'b0, 1'b0, 16'h0080, 3'b000);
    vec("nan",         1'b1, 10'd254, 16'h8000, 1'b1, 1'b0, 1'b0, 16'h7FC0, 3'b000);
    vec("inf",         1'b1, 10'd127, 16'h4000, 1'b0, 1'b1, 1'b0, 16'hFF80, 3'b000);
    vec("zero",        1'b1, 10'd254, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 3'b000);
    vec("nan_over_inf",1'b0, 10'd127, 16'h4000, 1'b1, 1'b1, 1'b0, 16'h7FC0, 3'b000);
    step();
    check("drain_idle", out_valid, 1'b0);

    // Backpressure: three back-to-back inputs against a stalled consumer.
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 16'h9000, 1'b0, 1'b0, 1'b0);
    check("bp_rdy_a", in_ready, 1'b1);
    step();
    drive(1'b0, 10'd127, 16'h40C0, 1'b0, 1'b0, 1'b0);
    check("bp_rdy_b", in_ready, 1'b1);
    step();
    drive(1'b0, 10'd127, 16'h4040, 1'b0, 1'b0, 1'b0);
    check("bp_full", in_ready, 1'b0);
    check("bp_a_valid", out_valid, 1'b1);
    check("bp_a_result", result, 16'h4010);
    for (int k = 0; k < 2; k++) begin
      step();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_result", result, 16'h4010);
      check("bp_hold_flags", {overflow, underflow, inexact}, 3'b000);
      check("bp_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy_comb", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_b_valid", out_valid, 1'b1);
    check("bp_b_result", result, 16'h3F82);
    step();
    check("bp_c_valid", out_valid, 1'b1);
    check("bp_c_result", result, 16'h3F80);
    step();
    check("bp_empty", out_valid, 1'b0);

`ifdef MUL_STATUS_STICKY_EN
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("st_cleared", status, 3'b000);
    vec("st_ovf", 1'b0, 10'd254, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h7F80, 3'b101);
    step();
    check("st_ovf_set", status, 3'b101);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("st_clr", status, 3'b000);
    vec("st_unf", 1'b0, 10'd0, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b011);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("st_set_wins", status, 3'b011);
`endif

    // Reset with two entries in flight.
    out_ready = 1'b0;
    send("rf_a", 1'b0, 10'd127, 16'h9000, 1'b0, 1'b0, 1'b0);
    send("rf_b", 1'b0, 10'd127, 16'h40C0, 1'b0, 1'b0, 1'b0);
    check("rf_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rf_async_valid", out_valid, 1'b0);
    check("rf_async_result", result, 16'h0000);
`ifdef MUL_STATUS_STICKY_EN
    check("rf_async_status", status, 3'b000);
`endif
    step();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rf_no_stale", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
